jump_physics_sequencer: RTL and testbench
=========================================

// Module: jump_physics_sequencer
// PURPOSE
//  Per-frame game-logic sequencer for Doodle Jump. On each frame tick it steps player vertical
//  physics, scans the platform table for a landing, scrolls the world and tracks game state/score.
//  Sits between the input controller (player_x, buttons, frame tick) and platform RAM / renderer.
// PARAMETERS
//  NUM_PLAT    8    platform table entries (power of 2, >=2)
//  SCREEN_H    480  visible height, px; player_y >= SCREEN_H => game over
//  START_Y     400  player_y on game start
//  JUMP_V      -12  vel_y loaded on start and on landing (signed)
//  GRAVITY     1    added to vel_y every frame
//  MAX_FALL    15   vel_y upper clamp
//  PLAYER_W    32   player sprite width, px
//  PLAYER_H    32   player sprite height, px
//  PLAT_W      64   platform width, px
//  SCROLL_LINE 160  player_y floor; rising above it scrolls the world
// PORTS
//  clk           in   1       clock
//  rst           in   1       reset, synchronous, active-high
//  frame_tick    in   1       1-cycle pulse per frame
//  button_any    in   1       left|right pressed, sampled at frame_tick
//  player_x      in   10      player left edge, px
//  plat_rd_en    out  1       platform RAM read strobe
//  plat_addr     out  clog2(NUM_PLAT)  platform index
//  plat_x        in   10      platform left edge, valid 1 cycle after rd_en
//  plat_y        in   9       platform top, valid 1 cycle after rd_en
//  player_y      out  11s     player top edge, signed
//  vel_y         out  6s      vertical velocity, px/frame, +down
//  scroll_valid  out  1       1-cycle pulse: world scrolls down by scroll_dy
//  scroll_dy     out  8       scroll amount, valid with scroll_valid
//  game_state    out  2       0 IDLE, 1 PLAY, 2 OVER
//  score         out  16      cumulative scrolled px, saturates at 16'hFFFF
//  busy          out  1       frame update in progress
//  frame_overrun out  1       sticky: frame_tick arrived while busy
// BEHAVIOUR
//  Reset: player_y=START_Y, vel_y=0, game_state=IDLE, score=0; all strobes/flags 0, FSM WAIT.
//  rst mid-frame aborts the scan immediately; no partial update is kept.
//  IDLE/OVER: frame_tick & button_any => PLAY, player_y=START_Y, vel_y=JUMP_V, score=0.
//    No physics runs on that tick. Ticks without button_any are ignored.
//  PLAY FSM: WAIT -> MOVE -> SCAN -> SCROLL -> CHECK -> WAIT.
//   WAIT: frame_tick => MOVE, busy=1 from the next cycle.
//   MOVE (1 cyc): y_prev=player_y; player_y+=vel_y; vel_y=min(vel_y+GRAVITY,MAX_FALL).
//     falling = (pre-update vel_y > 0).
//   SCAN: rd_en=1 on consecutive cycles, addr 0..NUM_PLAT-1; each data beat is checked 1 cycle later.
//     Hit iff falling && y_prev+PLAYER_H <= plat_y && player_y+PLAYER_H >= plat_y
//     && player_x+PLAYER_W > plat_x && player_x < plat_x+PLAT_W (compare at 11 bits, no wrap).
//     First hit (lowest index) wins: player_y=plat_y-PLAYER_H, vel_y=JUMP_V.
//     rd_en drops the next cycle; in-flight beats are ignored. No hit: scan ends after the last beat.
//   SCROLL (1 cyc): if player_y<SCROLL_LINE: scroll_dy=SCROLL_LINE-player_y (sat 255),
//     player_y=SCROLL_LINE, scroll_valid=1, score+=scroll_dy (saturating). Else no pulse.
//   CHECK (1 cyc): player_y>=SCREEN_H => game_state=OVER. busy=0 on return to WAIT.
//  Worst-case latency, tick to busy=0: NUM_PLAT+4 cycles.
//  frame_tick while busy (any state but WAIT): ignored, frame_overrun=1 until rst.
//  frame_tick coincident with returning to WAIT: treated as overrun, not started.
//  vel_y arithmetic is 6-bit signed, clamped before truncation. player_y never wraps.
// STRUCTURE
//  doodle_pkg: game_state_t enum (IDLE/PLAY/OVER), seq_state_t enum, geometry constants.
//  Sub-module landing_check: combinational hit test (y_prev, player_y, player_x, plat_x/y, falling).
//  The 1-cycle RAM latency is tracked by a registered valid + index alongside the scan counter.
// TESTING
//  rst, IDLE, tick+button_any => PLAY, player_y=400, vel_y=-12, score=0, no RAM reads.
//  PLAY, 1 tick, no platforms hit => player_y=388, vel_y=-11, 8 rd_en cycles, busy low after 12 cyc.
//  vel_y=5, player_y=300, plat[3]=(x=100,y=334), player_x=120 => player_y=302, vel_y=-12, scan stops.
//  player_y=165, vel_y=-10 => MOVE 155 -> scroll_valid, scroll_dy=5, player_y=160, score+=5.
//  vel_y=15, player_y=470, no hit => game_state=OVER; next tick+button => PLAY, reinit.
//  frame_tick 3 cycles after previous tick => ignored, frame_overrun=1; rst mid-SCAN => reset values.

Source files
------------

// File: rtl/jump_physics_sequencer_pkg.sv
// Shared types and default geometry for the jump physics sequencer.
//  game_state_t : externally visible game state (IDLE/PLAY/OVER)
//  seq_state_t  : per-frame update sequence
//  DEF_*        : default geometry/physics constants used as parameter defaults
//  sat_s11      : clamp a 12-bit signed value into the 11-bit signed player_y range
package jump_physics_sequencer_pkg;

    typedef enum logic [1:0] {
        GS_IDLE = 2'd0,
        GS_PLAY = 2'd1,
        GS_OVER = 2'd2
    } game_state_t;

    typedef enum logic [2:0] {
        SEQ_WAIT,
        SEQ_MOVE,
        SEQ_SCAN,
        SEQ_SCROLL,
        SEQ_CHECK
    } seq_state_t;

    localparam int DEF_NUM_PLAT    = 8;
    localparam int DEF_SCREEN_H    = 480;
    localparam int DEF_START_Y     = 400;
    localparam int DEF_JUMP_V      = -12;
    localparam int DEF_GRAVITY     = 1;
    localparam int DEF_MAX_FALL    = 15;
    localparam int DEF_PLAYER_W    = 32;
    localparam int DEF_PLAYER_H    = 32;
    localparam int DEF_PLAT_W      = 64;
    localparam int DEF_SCROLL_LINE = 160;

    function automatic logic signed [10:0] sat_s11(input logic signed [11:0] v);
        if (v > 12'sd1023) begin
            return 11'sd1023;
        end else if (v < -12'sd1024) begin
            return -11'sd1024;
        end else begin
            return v[10:0];
        end
    endfunction

endpackage

// File: rtl/jump_physics_sequencer_if.sv
// Platform RAM read bus.
//  plat_rd_en : read strobe (master -> RAM)
//  plat_addr  : platform index (master -> RAM)
//  plat_x     : platform left edge, valid 1 cycle after plat_rd_en (RAM -> master)
//  plat_y     : platform top, valid 1 cycle after plat_rd_en (RAM -> master)
interface jump_physics_sequencer_if
    import jump_physics_sequencer_pkg::*;
#(
    parameter int ADDR_W = $clog2(DEF_NUM_PLAT)
);
    logic              plat_rd_en;
    logic [ADDR_W-1:0] plat_addr;
    logic [9:0]        plat_x;
    logic [8:0]        plat_y;

    modport master (output plat_rd_en, output plat_addr, input plat_x, input plat_y);
    modport slave  (input plat_rd_en, input plat_addr, output plat_x, output plat_y);
endinterface

// File: rtl/jump_physics_sequencer_landing_check.sv
// Combinational landing test of the player against one platform.
//  falling  : player was moving down before this frame's velocity update
//  y_prev   : player top before the move;  player_y : player top after the move
//  player_x : player left edge;  plat_x/plat_y : platform left edge / top
//  hit      : player's bottom edge crossed the platform top this frame with
//             horizontal overlap
module jump_physics_sequencer_landing_check
    import jump_physics_sequencer_pkg::*;
#(
    parameter int PLAYER_W = DEF_PLAYER_W,
    parameter int PLAYER_H = DEF_PLAYER_H,
    parameter int PLAT_W   = DEF_PLAT_W
) (
    input  logic               falling,
    input  logic signed [10:0] y_prev,
    input  logic signed [10:0] player_y,
    input  logic        [9:0]  player_x,
    input  logic        [9:0]  plat_x,
    input  logic        [8:0]  plat_y,
    output logic               hit
);
    // One extra bit of headroom so that edge + size sums never wrap.
    localparam logic signed [11:0] PH12 = 12'(PLAYER_H);
    localparam logic signed [11:0] PW12 = 12'(PLAYER_W);
    localparam logic signed [11:0] LW12 = 12'(PLAT_W);

    logic signed [11:0] bot_prev;
    logic signed [11:0] bot_now;
    logic signed [11:0] py12;
    logic signed [11:0] px12;
    logic signed [11:0] ux12;

    assign bot_prev = {y_prev[10], y_prev} + PH12;
    assign bot_now  = {player_y[10], player_y} + PH12;
    assign py12     = $signed({3'b000, plat_y});
    assign px12     = $signed({2'b00, plat_x});
    assign ux12     = $signed({2'b00, player_x});

    assign hit = falling
              && (bot_prev <= py12) && (bot_now >= py12)
              && (ux12 + PW12 > px12) && (ux12 < px12 + LW12);
endmodule

// File: rtl/jump_physics_sequencer.sv
// Per-frame game-logic sequencer: steps vertical physics, scans the platform
// table for a landing, scrolls the world and tracks game state and score.
//  clk, rst       : clock, synchronous active-high reset
//  frame_tick     : 1-cycle pulse per frame;  button_any : start request
//  player_x       : player left edge
//  plat_bus       : platform RAM read bus (1-cycle read latency)
//  player_y/vel_y : player top edge / vertical velocity (signed, +down)
//  scroll_valid/scroll_dy : 1-cycle scroll pulse and amount
//  game_state, score, busy, frame_overrun (sticky)
module jump_physics_sequencer
    import jump_physics_sequencer_pkg::*;
#(
    parameter int NUM_PLAT    = DEF_NUM_PLAT,
    parameter int SCREEN_H    = DEF_SCREEN_H,
    parameter int START_Y     = DEF_START_Y,
    parameter int JUMP_V      = DEF_JUMP_V,
    parameter int GRAVITY     = DEF_GRAVITY,
    parameter int MAX_FALL    = DEF_MAX_FALL,
    parameter int PLAYER_W    = DEF_PLAYER_W,
    parameter int PLAYER_H    = DEF_PLAYER_H,
    parameter int PLAT_W      = DEF_PLAT_W,
    parameter int SCROLL_LINE = DEF_SCROLL_LINE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_tick,
    input  logic                     button_any,
    input  logic               [9:0] player_x,
    jump_physics_sequencer_if.master plat_bus,
    output logic signed       [10:0] player_y,
    output logic signed        [5:0] vel_y,
    output logic                     scroll_valid,
    output logic               [7:0] scroll_dy,
    output logic               [1:0] game_state,
    output logic              [15:0] score,
    output logic                     busy,
    output logic                     frame_overrun
);
    localparam int                      ADDR_W     = $clog2(NUM_PLAT);
    localparam logic [ADDR_W-1:0]       LAST_IDX   = ADDR_W'(NUM_PLAT - 1);
    localparam logic signed [10:0]      START_Y11  = 11'(START_Y);
    localparam logic signed [10:0]      SCREEN_H11 = 11'(SCREEN_H);
    localparam logic signed [10:0]      PLAYER_H11 = 11'(PLAYER_H);
    localparam logic signed [10:0]      SCROLL_11  = 11'(SCROLL_LINE);
    localparam logic signed [11:0]      SCROLL_12  = 12'(SCROLL_LINE);
    localparam logic signed [5:0]       JUMP_V6    = 6'(JUMP_V);
    localparam logic signed [6:0]       GRAVITY7   = 7'(GRAVITY);
    localparam logic signed [6:0]       MAX_FALL7  = 7'(MAX_FALL);

    seq_state_t         seq_state_reg, seq_state_next;
    game_state_t        game_state_reg, game_state_next;
    logic signed [10:0] player_y_reg, player_y_next;
    logic signed [10:0] y_prev_reg, y_prev_next;
    logic signed [5:0]  vel_y_reg, vel_y_next;
    logic               falling_reg, falling_next;
    logic [ADDR_W-1:0]  issue_idx_reg, issue_idx_next;
    logic               issue_done_reg, issue_done_next;
    logic               scroll_valid_reg, scroll_valid_next;
    logic [7:0]         scroll_dy_reg, scroll_dy_next;
    logic [15:0]        score_reg, score_next;
    logic               overrun_reg, overrun_next;
    // Read-latency tracking: which address the current RAM data belongs to.
    logic               beat_valid_reg;
    logic [ADDR_W-1:0]  beat_idx_reg;

    logic               rd_en;
    logic               hit;
    logic signed [11:0] y_ext;
    logic signed [11:0] y_sum;
    logic signed [6:0]  vel_sum;
    logic signed [5:0]  vel_clamped;
    logic signed [11:0] scroll_gap;
    logic [7:0]         dy_sat;
    logic [16:0]        score_sum;
    logic signed [10:0] land_y;

    assign rd_en       = (seq_state_reg == SEQ_SCAN) && !issue_done_reg;
    assign y_ext       = {player_y_reg[10], player_y_reg};
    assign y_sum       = y_ext + {{6{vel_y_reg[5]}}, vel_y_reg};
    assign vel_sum     = {vel_y_reg[5], vel_y_reg} + GRAVITY7;
    // Clamp in 7 bits before truncating back to the 6-bit velocity.
    assign vel_clamped = (vel_sum > MAX_FALL7) ? MAX_FALL7[5:0] : vel_sum[5:0];
    assign scroll_gap  = SCROLL_12 - y_ext;
    assign dy_sat      = (scroll_gap > 12'sd255) ? 8'hFF : scroll_gap[7:0];
    assign score_sum   = {1'b0, score_reg} + {9'd0, dy_sat};
    assign land_y      = $signed({2'b00, plat_bus.plat_y}) - PLAYER_H11;

    jump_physics_sequencer_landing_check #(
        .PLAYER_W(PLAYER_W),
        .PLAYER_H(PLAYER_H),
        .PLAT_W  (PLAT_W)
    ) u_landing (
        .falling (falling_reg),
        .y_prev  (y_prev_reg),
        .player_y(player_y_reg),
        .player_x(player_x),
        .plat_x  (plat_bus.plat_x),
        .plat_y  (plat_bus.plat_y),
        .hit     (hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_state_reg    <= SEQ_WAIT;
            game_state_reg   <= GS_IDLE;
            player_y_reg     <= START_Y11;
            y_prev_reg       <= START_Y11;
            vel_y_reg        <= '0;
            falling_reg      <= 1'b0;
            issue_idx_reg    <= '0;
            issue_done_reg   <= 1'b0;
            scroll_valid_reg <= 1'b0;
            scroll_dy_reg    <= '0;
            score_reg        <= '0;
            overrun_reg      <= 1'b0;
            beat_valid_reg   <= 1'b0;
            beat_idx_reg     <= '0;
        end else begin
            seq_state_reg    <= seq_state_next;
            game_state_reg   <= game_state_next;
            player_y_reg     <= player_y_next;
            y_prev_reg       <= y_prev_next;
            vel_y_reg        <= vel_y_next;
            falling_reg      <= falling_next;
            issue_idx_reg    <= issue_idx_next;
            issue_done_reg   <= issue_done_next;
            scroll_valid_reg <= scroll_valid_next;
            scroll_dy_reg    <= scroll_dy_next;
            score_reg        <= score_next;
            overrun_reg      <= overrun_next;
            beat_valid_reg   <= rd_en;
            beat_idx_reg     <= issue_idx_reg;
        end
    end

    always_comb begin
        seq_state_next    = seq_state_reg;
        game_state_next   = game_state_reg;
        player_y_next     = player_y_reg;
        y_prev_next       = y_prev_reg;
        vel_y_next        = vel_y_reg;
        falling_next      = falling_reg;
        issue_idx_next    = issue_idx_reg;
        issue_done_next   = issue_done_reg;
        scroll_valid_next = 1'b0;
        scroll_dy_next    = scroll_dy_reg;
        score_next        = score_reg;
        overrun_next      = overrun_reg;

        // Includes a tick landing in CHECK: that frame is dropped, not queued.
        if (frame_tick && (seq_state_reg != SEQ_WAIT)) begin
            overrun_next = 1'b1;
        end

        case (seq_state_reg)
            SEQ_WAIT: begin
                if (frame_tick) begin
                    if (game_state_reg == GS_PLAY) begin
                        seq_state_next = SEQ_MOVE;
                    end else if (button_any) begin
                        game_state_next = GS_PLAY;
                        player_y_next   = START_Y11;
                        vel_y_next      = JUMP_V6;
                        score_next      = '0;
                    end
                end
            end
            SEQ_MOVE: begin
                y_prev_next     = player_y_reg;
                player_y_next   = sat_s11(y_sum);
                vel_y_next      = vel_clamped;
                falling_next    = (vel_y_reg > 6'sd0);
                issue_idx_next  = '0;
                issue_done_next = 1'b0;
                seq_state_next  = SEQ_SCAN;
            end
            SEQ_SCAN: begin
                if (rd_en) begin
                    if (issue_idx_reg == LAST_IDX) begin
                        issue_done_next = 1'b1;
                    end else begin
                        issue_idx_next = issue_idx_reg + 1'b1;
                    end
                end
                // Leaving SCAN on a hit drops rd_en; the beat still in flight
                // arrives during SCROLL and is never examined.
                if (beat_valid_reg) begin
                    if (hit) begin
                        player_y_next  = land_y;
                        vel_y_next     = JUMP_V6;
                        seq_state_next = SEQ_SCROLL;
                    end else if (beat_idx_reg == LAST_IDX) begin
                        seq_state_next = SEQ_SCROLL;
                    end
                end
            end
            SEQ_SCROLL: begin
                if (player_y_reg < SCROLL_11) begin
                    scroll_dy_next    = dy_sat;
                    scroll_valid_next = 1'b1;
                    player_y_next     = SCROLL_11;
                    score_next        = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                end
                seq_state_next = SEQ_CHECK;
            end
            SEQ_CHECK: begin
                if (player_y_reg >= SCREEN_H11) begin
                    game_state_next = GS_OVER;
                end
                seq_state_next = SEQ_WAIT;
            end
            default: seq_state_next = SEQ_WAIT;
        endcase
    end

    assign plat_bus.plat_rd_en = rd_en;
    assign plat_bus.plat_addr  = issue_idx_reg;
    assign player_y            = player_y_reg;
    assign vel_y               = vel_y_reg;
    assign scroll_valid        = scroll_valid_reg;
    assign scroll_dy           = scroll_dy_reg;
    assign game_state          = game_state_reg;
    assign score               = score_reg;
    assign busy                = (seq_state_reg != SEQ_WAIT);
    assign frame_overrun       = overrun_reg;
endmodule

// File: tb/tb_jump_physics_sequencer.sv
// Directed bench for jump_physics_sequencer: a behavioural frame model pushes
// expected results to a scoreboard when a tick is driven; they are popped and
// compared when the frame completes.
module tb_jump_physics_sequencer;
    localparam int NP = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               frame_tick = 1'b0;
    logic               button_any = 1'b0;
    logic [9:0]         player_x = 10'd120;
    logic signed [10:0] player_y;
    logic signed [5:0]  vel_y;
    logic               scroll_valid;
    logic [7:0]         scroll_dy;
    logic [1:0]         game_state;
    logic [15:0]        score;
    logic               busy;
    logic               frame_overrun;

    jump_physics_sequencer_if #(.ADDR_W(3)) plat_bus ();

    jump_physics_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .button_any   (button_any),
        .player_x     (player_x),
        .plat_bus     (plat_bus),
        .player_y     (player_y),
        .vel_y        (vel_y),
        .scroll_valid (scroll_valid),
        .scroll_dy    (scroll_dy),
        .game_state   (game_state),
        .score        (score),
        .busy         (busy),
        .frame_overrun(frame_overrun)
    );

    always #5 clk = ~clk;

    // Platform RAM with 1-cycle registered read.
    logic [9:0] mem_x [NP];
    logic [8:0] mem_y [NP];
    always @(posedge clk) begin
        if (plat_bus.plat_rd_en) begin
            plat_bus.plat_x <= mem_x[plat_bus.plat_addr];
            plat_bus.plat_y <= mem_y[plat_bus.plat_addr];
        end
    end

    typedef struct {
        int y; int v; int score; int state; int rd; int busy; int scrolls; int dy;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;
    int m_y, m_v, m_score, m_state;

    task automatic check(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_y = 400; m_v = 0; m_score = 0; m_state = 0;
    endtask

    task automatic model_frame(output exp_t e);
        int y_prev, hit, py, px, ux;
        bit fall;
        y_prev = m_y;
        fall   = (m_v > 0);
        m_y    = m_y + m_v;
        m_v    = (m_v + 1 > 15) ? 15 : m_v + 1;
        hit    = -1;
        ux     = int'(player_x);
        for (int i = 0; i < NP; i++) begin
            py = int'(mem_y[i]);
            px = int'(mem_x[i]);
            if (hit < 0 && fall && y_prev + 32 <= py && m_y + 32 >= py
                && ux + 32 > px && ux < px + 64) hit = i;
        end
        if (hit >= 0) begin
            m_y    = int'(mem_y[hit]) - 32;
            m_v    = -12;
            e.rd   = (hit + 2 > NP) ? NP : hit + 2;
            e.busy = hit + 5;
        end else begin
            e.rd   = NP;
            e.busy = NP + 4;
        end
        e.scrolls = 0;
        e.dy      = 0;
        if (m_y < 160) begin
            e.scrolls = 1;
            e.dy      = (160 - m_y > 255) ? 255 : 160 - m_y;
            m_y       = 160;
            m_score   = (m_score + e.dy > 65535) ? 65535 : m_score + e.dy;
        end
        if (m_y >= 480) m_state = 2;
        e.y = m_y; e.v = m_v; e.score = m_score; e.state = m_state;
    endtask

    task automatic compare_pop(input string tag, input int n, input int rdc,
                               input int sc, input int dy);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_y"}, int'(player_y), e.y);
        check({tag, "_vel"}, int'(vel_y), e.v);
        check({tag, "_score"}, int'(score), e.score);
        check({tag, "_state"}, int'(game_state), e.state);
        check({tag, "_rd"}, rdc, e.rd);
        check({tag, "_busy"}, n, e.busy);
        check({tag, "_scrolls"}, sc, e.scrolls);
        if (e.scrolls != 0) check({tag, "_dy"}, dy, e.dy);
        $display("%s: y=%0d vel=%0d score=%0d state=%0d rd=%0d busy=%0d scroll=%0d",
                 tag, int'(player_y), int'(vel_y), int'(score), int'(game_state), rdc, n, sc);
    endtask

    // Drives one PLAY-frame tick; optionally injects a second tick after the
    // extra_at-th busy cycle.
    task automatic do_frame(input string tag, input int extra_at);
        exp_t e;
        int n, rdc, sc, dy;
        bit done;
        model_frame(e);
        sb.push_back(e);
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        n = 0; rdc = 0; sc = 0; dy = 0; done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
            n++;
            if (plat_bus.plat_rd_en) rdc++;
            if (scroll_valid) begin
                sc++;
                dy = int'(scroll_dy);
            end
            frame_tick = (n == extra_at);
        end
        frame_tick = 1'b0;
        check({tag, "_done"}, int'(done), 1);
        compare_pop(tag, n, rdc, sc, dy);
    endtask

    // Tick while not playing: starts a game only with button_any.
    task automatic start_tick(input string tag, input logic btn);
        exp_t e;
        int n, rdc;
        if (m_state != 1 && btn) begin
            m_y = 400; m_v = -12; m_score = 0; m_state = 1;
        end
        e.y = m_y; e.v = m_v; e.score = m_score; e.state = m_state;
        e.rd = 0; e.busy = 0; e.scrolls = 0; e.dy = 0;
        sb.push_back(e);
        @(posedge clk); #1 frame_tick = 1'b1; button_any = btn;
        @(posedge clk); #1 frame_tick = 1'b0; button_any = 1'b0;
        n = 0; rdc = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (busy) n++;
            if (plat_bus.plat_rd_en) rdc++;
        end
        compare_pop(tag, n, rdc, 0, 0);
    endtask

    task automatic far_all();
        for (int i = 0; i < NP; i++) begin
            mem_x[i] = 10'd900;
            mem_y[i] = 9'd0;
        end
    endtask

    initial begin
        int f;
        far_all();
        // Frame 18 lands: index 3 wins over index 5; 0 and 1 sit exactly on
        // the horizontal overlap boundaries and must not hit.
        mem_x[0] = 10'd56;  mem_y[0] = 9'd366;
        mem_x[1] = 10'd152; mem_y[1] = 9'd366;
        mem_x[3] = 10'd100; mem_y[3] = 9'd366;
        mem_x[5] = 10'd110; mem_y[5] = 9'd368;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_y", int'(player_y), 400);
        check("rst_vel", int'(vel_y), 0);
        check("rst_state", int'(game_state), 0);
        check("rst_score", int'(score), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(frame_overrun), 0);
        check("rst_scroll", int'(scroll_valid), 0);
        check("rst_rd_en", int'(plat_bus.plat_rd_en), 0);

        start_tick("idle_nobtn", 1'b0);
        start_tick("start", 1'b1);

        for (f = 1; f <= 18; f++) begin
            do_frame($sformatf("f%0d", f), -1);
            if (f == 1) begin
                check("f1_y_const", int'(player_y), 388);
                check("f1_vel_const", int'(vel_y), -11);
            end
        end
        check("land_y_const", int'(player_y), 334);
        check("land_vel_const", int'(vel_y), -12);

        // Staircase: a platform under the player each time it starts falling.
        far_all();
        for (int k = 0; k < 70; k++) begin
            if (m_v > 0 && m_y >= 0 && m_y < 400) begin
                mem_x[2] = 10'd100;
                mem_y[2] = 9'(m_y + 32 + m_v / 2);
            end else begin
                mem_x[2] = 10'd900;
            end
            do_frame($sformatf("stair%0d", k), -1);
        end
        check("score_nonzero", int'(score != 16'd0), 1);

        far_all();
        for (int k = 0; k < 80 && m_state == 1; k++) begin
            do_frame($sformatf("fall%0d", k), -1);
        end
        check("over_state", int'(game_state), 2);
        check("over_vel_clamp", int'(vel_y), 15);
        check("no_overrun_yet", int'(frame_overrun), 0);

        start_tick("over_nobtn", 1'b0);
        start_tick("restart", 1'b1);

        do_frame("ovr_frame", 3);
        check("overrun_set", int'(frame_overrun), 1);

        // Reset in the middle of a scan.
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        repeat (4) @(posedge clk);
        check("midscan_busy", int'(busy), 1);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("mrst_y", int'(player_y), 400);
        check("mrst_vel", int'(vel_y), 0);
        check("mrst_state", int'(game_state), 0);
        check("mrst_score", int'(score), 0);
        check("mrst_busy", int'(busy), 0);
        check("mrst_overrun", int'(frame_overrun), 0);

        start_tick("start2", 1'b1);
        // Tick arriving on the CHECK cycle: overrun, no new frame.
        do_frame("coinc_frame", 12);
        check("coinc_overrun", int'(frame_overrun), 1);
        begin
            int nb;
            nb = 0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (busy) nb++;
            end
            check("coinc_not_started", nb, 0);
        end
        check("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
